gpio_packet_scan: RTL

- Serial front end for the OpenRAM test chip, directly upstream of the SRAM access stage.
- Deserialises a command packet shifted in over GPIO pins and presents it as the parallel packet: chip_select in bits [85:83], SRAM control/address/data in [82:0].
- Waits a fixed latency, captures the 64-bit SRAM read data returned by that stage, then shifts it back out on a GPIO pin.
- Lets the whole chip be exercised from GPIO alone, without the logic analyzer.

---
 rtl/openram_tc_pkg.sv | 29 ++
 rtl/scan_shift_reg.sv | 30 +++
 rtl/gpio_packet_scan.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/openram_tc_pkg.sv
// Shared widths, packet layout and scan FSM encodings for the OpenRAM test chip front end.
package openram_tc_pkg;

    localparam int unsigned PACKET_W = 86;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned CS_LSB   = 83;
    localparam int unsigned CS_MSB   = 85;
    localparam int unsigned CS_W     = CS_MSB - CS_LSB + 1;
    localparam int unsigned CMD_W    = CS_LSB;
    localparam int unsigned CNT_W    = $clog2((PACKET_W > DATA_W) ? PACKET_W : DATA_W);

    // All chip selects high means no SRAM is addressed.
    localparam logic [CS_W-1:0] CS_NONE = 3'd7;

    typedef struct packed {
        logic [CS_W-1:0]  chip_select;
        logic [CMD_W-1:0] sram_cmd;
    } scan_packet_t;

    typedef logic [2:0] scan_state_t;

    localparam scan_state_t S_IDLE    = 3'd0;
    localparam scan_state_t S_SHIFT   = 3'd1;
    localparam scan_state_t S_COMMIT  = 3'd2;
    localparam scan_state_t S_WAIT    = 3'd3;
    localparam scan_state_t S_CAPTURE = 3'd4;
    localparam scan_state_t S_UNLOAD  = 3'd5;

endpackage

// File: rtl/scan_shift_reg.sv
// MSB-first shift register with parallel load; load takes priority over shift.
module scan_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= parallel_in;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], serial_in};
        end
    end

    assign serial_out   = sr[WIDTH-1];
    assign parallel_out = sr;

endmodule

// File: rtl/gpio_packet_scan.sv
// GPIO scan front end: shifts in a command packet, waits a fixed latency,
// captures SRAM read data and shifts it back out MSB first.
module gpio_packet_scan
    import openram_tc_pkg::*;
#(
    parameter int unsigned CAPTURE_DELAY = 3
) (
    input  logic                gpio_clock,
    input  logic                reset,
    input  logic                scan_start,
    input  logic                scan_en,
    input  logic                scan_in,
    input  logic [DATA_W-1:0]   sram_data,
    output logic [PACKET_W-1:0] packet,
    output logic                packet_valid,
    output logic                scan_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned WAIT_W = $clog2(CAPTURE_DELAY + 1);

    scan_state_t       state;
    scan_state_t       state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;

    logic in_load;
    logic in_shift;
    logic out_load;
    logic out_shift;
    logic commit;
    logic done_next;
    logic scan_out_next;

    logic [PACKET_W-1:0] in_par;
    logic [DATA_W-1:0]   out_par;
    logic                in_msb_unused;
    logic                out_msb_unused;
    scan_packet_t        packet_q;

    scan_shift_reg #(.WIDTH(PACKET_W)) u_in_sr (
        .clk          (gpio_clock),
        .rst          (reset),
        .load         (in_load),
        .shift        (in_shift),
        .serial_in    (scan_in),
        .parallel_in  ('0),
        .serial_out   (in_msb_unused),
        .parallel_out (in_par)
    );

    scan_shift_reg #(.WIDTH(DATA_W)) u_out_sr (
        .clk          (gpio_clock),
        .rst          (reset),
        .load         (out_load),
        .shift        (out_shift),
        .serial_in    (1'b0),
        .parallel_in  (sram_data),
        .serial_out   (out_msb_unused),
        .parallel_out (out_par)
    );

    // Next-state, counter and control decode.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        wait_cnt_next = wait_cnt;
        in_load       = 1'b0;
        in_shift      = 1'b0;
        out_load      = 1'b0;
        out_shift     = 1'b0;
        commit        = 1'b0;
        done_next     = 1'b0;
        scan_out_next = 1'b0;

        case (state)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the finished transaction.
                if (scan_start && !done) begin
                    state_next   = S_SHIFT;
                    bit_cnt_next = '0;
                    in_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (scan_en) begin
                    in_shift     = 1'b1;
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(PACKET_W - 1)) begin
                        state_next = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                commit        = 1'b1;
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt + WAIT_W'(1);
                if (wait_cnt == WAIT_W'(CAPTURE_DELAY - 1)) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                out_load      = 1'b1;
                bit_cnt_next  = '0;
                state_next    = S_UNLOAD;
                scan_out_next = sram_data[DATA_W-1];
            end
            S_UNLOAD: begin
                scan_out_next = scan_out;
                if (scan_en) begin
                    out_shift     = 1'b1;
                    bit_cnt_next  = bit_cnt + CNT_W'(1);
                    scan_out_next = out_par[DATA_W-2];
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state_next    = S_IDLE;
                        done_next     = 1'b1;
                        scan_out_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; scan_out tracks the MSB the output register will hold.
    always_ff @(posedge gpio_clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            packet_q     <= '{chip_select: CS_NONE, sram_cmd: '1};
            packet_valid <= 1'b0;
            scan_out     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            wait_cnt     <= wait_cnt_next;
            packet_valid <= commit;
            scan_out     <= scan_out_next;
            busy         <= (state_next != S_IDLE);
            done         <= done_next;
            if (commit) begin
                packet_q <= scan_packet_t'(in_par);
            end
        end
    end

    assign packet = packet_q;

endmodule
